// File: rtl/wgt_buf_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wgt_feed_pkg
// Purpose : Shared types and constants for the weight-buffer feeder.
//           Holds the FSM state encoding, the buffer read latency, the bank
//           capacity and the depth helper also used by img2col_weight.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package wgt_feed_pkg;

    // Cycles from rd_en to rd_data valid at the buffer output
    localparam int RD_LAT     = 2;
    // Words per lane per bank: 9 taps x 8 channels
    localparam int BANK_DEPTH = 72;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BANK = 3'd1,
        ISSUE     = 3'd2,
        DRAIN     = 3'd3,
        RELEASE   = 3'd4
    } state_t;

    // Words per lane in one bank: kernel_size^2 * (chn_num + 1).
    // The product is truncated to 8 bits, matching the writer's counter.
    function automatic logic [7:0] calc_depth(input logic [3:0] kernel_size,
                                              input logic [2:0] chn_num);
        logic [10:0] w_prod;
        w_prod = 11'(kernel_size) * 11'(kernel_size) * (11'(chn_num) + 11'd1);
        return w_prod[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/wgt_buf_feeder_if.sv
`default_nettype none
// ============================================================================
// Module  : wgt_buf_feeder_if
// Purpose : Bus bundle between the feeder, the ping-pong weight buffer read
//           port and the systolic array weight inputs.
// Signals : rd_en/rd_bank_sel/rd_addr -> buffer, rd_data <- buffer,
//           wgt_out/wgt_vld/wgt_last -> array, arr_ready <- array.
// Modports: master = feeder, slave = buffer/array side.
// Rev     : 1.0  initial release
// ============================================================================
interface wgt_buf_feeder_if #(
    parameter int DATA_WID = 16,
    parameter int SIZE     = 8,
    parameter int ADDR_WID = 7
);
    logic                           rd_en;
    logic                           rd_bank_sel;
    logic [ADDR_WID-1:0]            rd_addr;
    logic [SIZE-1:0][DATA_WID-1:0]  rd_data;
    logic [SIZE-1:0][DATA_WID-1:0]  wgt_out;
    logic [SIZE-1:0]                wgt_vld;
    logic [SIZE-1:0]                wgt_last;
    logic                           arr_ready;

    modport master (
        output rd_en, rd_bank_sel, rd_addr, wgt_out, wgt_vld, wgt_last,
        input  rd_data, arr_ready
    );

    modport slave (
        input  rd_en, rd_bank_sel, rd_addr, wgt_out, wgt_vld, wgt_last,
        output rd_data, arr_ready
    );
endinterface
`default_nettype wire

// File: rtl/wgt_buf_feeder_skew_line.sv
`default_nettype none
// ============================================================================
// Module  : wgt_skew_line
// Purpose : One lane of the diagonal skew triangle. Delays data, valid and
//           last by DLY register stages; data is zeroed when not valid.
// Ports   : clk, rst          clock / sync active-high reset
//           i_data/i_vld/i_last  lane input from the buffer read return
//           o_data/o_vld/o_last  lane output to the array
// Rev     : 1.0  initial release
// ============================================================================
module wgt_skew_line #(
    parameter int DATA_WID = 16,
    parameter int DLY      = 1
) (
    input  wire logic                clk,
    input  wire logic                rst,
    input  wire logic [DATA_WID-1:0] i_data,
    input  wire logic                i_vld,
    input  wire logic                i_last,
    output logic      [DATA_WID-1:0] o_data,
    output logic                     o_vld,
    output logic                     o_last
);
    logic [DLY-1:0][DATA_WID-1:0] r_data;
    logic [DLY-1:0]               r_vld;
    logic [DLY-1:0]               r_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_vld  <= '0;
            r_last <= '0;
        end else begin
            // Gate at capture so the whole chain only ever carries real words
            r_data[0] <= i_vld ? i_data : '0;
            r_vld[0]  <= i_vld;
            r_last[0] <= i_vld & i_last;
            for (int k = 1; k < DLY; k++) begin
                r_data[k] <= r_data[k-1];
                r_vld[k]  <= r_vld[k-1];
                r_last[k] <= r_last[k-1];
            end
        end
    end

    assign o_data = r_data[DLY-1];
    assign o_vld  = r_vld[DLY-1];
    assign o_last = r_last[DLY-1];
endmodule
`default_nettype wire

// File: rtl/wgt_buf_feeder.sv
`default_nettype none
// ============================================================================
// Module  : wgt_buf_feeder
// Purpose : Drains the ping-pong weight buffer into the systolic array.
//           Tracks bank fullness, issues gap-free reads per pass, replays a
//           bank rpt_num+1 times, releases it and moves to the other bank.
// Ports   : clk, rst                 clock / sync active-high reset
//           i_start + config         job start, kernel/chn/tile/rpt config
//           i_bank_fill(_sel)        writer reports a bank as full
//           o_bank_free[1:0]         one-cycle release pulse per bank
//           o_busy/o_done            job status / end-of-job pulse
//           o_cfg_err/o_ovf_err      sticky errors, cleared on start
//           bus (master)             buffer read port + array weight port
// Rev     : 1.0  initial release
// ============================================================================
module wgt_buf_feeder #(
    parameter int DATA_WID   = 16,
    parameter int SIZE       = 8,
    parameter int ADDR_WID   = 7,
    parameter int BANK_DEPTH = wgt_feed_pkg::BANK_DEPTH
) (
    input  wire logic       clk,
    input  wire logic       rst,
    input  wire logic       i_start,
    input  wire logic [3:0] i_kernel_size,
    input  wire logic [2:0] i_chn_num,
    input  wire logic [2:0] i_tile_num,
    input  wire logic [2:0] i_rpt_num,
    input  wire logic       i_bank_fill,
    input  wire logic       i_bank_fill_sel,
    output logic      [1:0] o_bank_free,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_cfg_err,
    output logic            o_ovf_err,
    wgt_buf_feeder_if.master bus
);
    import wgt_feed_pkg::*;

    // Drain covers the last word's read latency plus the full lane skew
    localparam int c_DRAIN_CYC = SIZE + 2;
    localparam int c_DRAIN_W   = $clog2(c_DRAIN_CYC);

    state_t                r_state;
    logic [1:0]            r_bank_full;
    logic                  r_cur_bank;
    logic [ADDR_WID-1:0]   r_last_addr;
    logic [ADDR_WID-1:0]   r_issue_cnt;
    logic [c_DRAIN_W-1:0]  r_drain_cnt;
    logic [2:0]            r_tile_num, r_rpt_num, r_tile_cnt, r_pass_cnt;
    logic                  r_rd_en, r_rd_bank, r_rd_last;
    logic [ADDR_WID-1:0]   r_rd_addr;
    logic [RD_LAT-1:0]     r_vld_pipe, r_last_pipe;

    logic [7:0] w_depth;
    logic       w_cfg_bad;
    logic [1:0] w_fill_hit, w_rel_hit;

    assign w_depth    = calc_depth(i_kernel_size, i_chn_num);
    assign w_cfg_bad  = (w_depth == 8'd0) || (w_depth > 8'(BANK_DEPTH));
    assign w_fill_hit = {i_bank_fill & i_bank_fill_sel, i_bank_fill & ~i_bank_fill_sel};
    assign w_rel_hit  = (r_state == RELEASE) ? {r_cur_bank, ~r_cur_bank} : 2'b00;

    // Control FSM with registered outputs; bank bookkeeping runs in every state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_bank_full <= '0;
            r_cur_bank  <= 1'b0;
            r_last_addr <= '0;
            r_issue_cnt <= '0;
            r_drain_cnt <= '0;
            r_tile_num  <= '0;
            r_rpt_num   <= '0;
            r_tile_cnt  <= '0;
            r_pass_cnt  <= '0;
            r_rd_en     <= 1'b0;
            r_rd_bank   <= 1'b0;
            r_rd_addr   <= '0;
            r_rd_last   <= 1'b0;
            o_bank_free <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_cfg_err   <= 1'b0;
            o_ovf_err   <= 1'b0;
        end else begin
            o_bank_free <= '0;
            o_done      <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        o_ovf_err <= 1'b0;
                        o_cfg_err <= w_cfg_bad;
                        if (!w_cfg_bad) begin
                            r_last_addr <= ADDR_WID'(w_depth - 8'd1);
                            r_tile_num  <= i_tile_num;
                            r_rpt_num   <= i_rpt_num;
                            r_tile_cnt  <= '0;
                            r_pass_cnt  <= '0;
                            o_busy      <= 1'b1;
                            r_state     <= WAIT_BANK;
                        end
                    end
                end
                WAIT_BANK: begin
                    if (r_bank_full[r_cur_bank] && bus.arr_ready) begin
                        r_issue_cnt <= '0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_rd_en   <= 1'b1;
                    r_rd_bank <= r_cur_bank;
                    r_rd_addr <= r_issue_cnt;
                    r_rd_last <= (r_issue_cnt == r_last_addr);
                    if (r_issue_cnt == r_last_addr) begin
                        r_drain_cnt <= '0;
                        r_state     <= DRAIN;
                    end else begin
                        r_issue_cnt <= r_issue_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    r_rd_en   <= 1'b0;
                    r_rd_last <= 1'b0;
                    r_rd_addr <= '0;
                    if (r_drain_cnt == c_DRAIN_W'(c_DRAIN_CYC - 1)) begin
                        if (r_pass_cnt == r_rpt_num) begin
                            r_pass_cnt              <= '0;
                            o_bank_free[r_cur_bank] <= 1'b1;
                            r_state                 <= RELEASE;
                        end else begin
                            r_pass_cnt <= r_pass_cnt + 1'b1;
                            r_state    <= WAIT_BANK;
                        end
                    end else begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    r_cur_bank <= ~r_cur_bank;
                    if (r_tile_cnt == r_tile_num) begin
                        r_tile_cnt <= '0;
                        o_done     <= 1'b1;
                        o_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        r_tile_cnt <= r_tile_cnt + 1'b1;
                        r_state    <= WAIT_BANK;
                    end
                end
                default: r_state <= IDLE;
            endcase

            // A fill into a bank that is still full (even in its release
            // cycle) is dropped and flagged; this set wins over the start clear.
            if (|(w_fill_hit & r_bank_full))
                o_ovf_err <= 1'b1;
            r_bank_full <= (r_bank_full | w_fill_hit) & ~w_rel_hit;
        end
    end

    // Align valid/last with the buffer's read return
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
        end else begin
            r_vld_pipe  <= {r_vld_pipe[RD_LAT-2:0], r_rd_en};
            r_last_pipe <= {r_last_pipe[RD_LAT-2:0], r_rd_last};
        end
    end

    logic [SIZE-1:0][DATA_WID-1:0] w_wgt_out;
    logic [SIZE-1:0]               w_wgt_vld, w_wgt_last;

    // Lane i gets i+1 stages: one capture stage plus i cycles of skew
    generate
        for (genvar i = 0; i < SIZE; i++) begin : g_lane
            wgt_skew_line #(
                .DATA_WID (DATA_WID),
                .DLY      (i + 1)
            ) u_skew (
                .clk    (clk),
                .rst    (rst),
                .i_data (bus.rd_data[i]),
                .i_vld  (r_vld_pipe[RD_LAT-1]),
                .i_last (r_last_pipe[RD_LAT-1]),
                .o_data (w_wgt_out[i]),
                .o_vld  (w_wgt_vld[i]),
                .o_last (w_wgt_last[i])
            );
        end
    endgenerate

    assign bus.rd_en       = r_rd_en;
    assign bus.rd_bank_sel = r_rd_bank;
    assign bus.rd_addr     = r_rd_addr;
    assign bus.wgt_out     = w_wgt_out;
    assign bus.wgt_vld     = w_wgt_vld;
    assign bus.wgt_last    = w_wgt_last;
endmodule
`default_nettype wire

// File: tb/tb_wgt_buf_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_wgt_buf_feeder
// Purpose : Self-checking bench for wgt_buf_feeder. Models the 2-cycle
//           buffer read port, queues expected reads, lane words and bank
//           releases, and checks them from an independent monitor.
// Rev     : 1.0  initial release
// ============================================================================
module tb_wgt_buf_feeder;
    localparam int DW = 16;
    localparam int SZ = 8;
    localparam int AW = 7;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] kernel_size = '0;
    logic [2:0] chn_num = '0, tile_num = '0, rpt_num = '0;
    logic       bank_fill = 1'b0, bank_fill_sel = 1'b0;
    logic [1:0] bank_free;
    logic       busy, done, cfg_err, ovf_err;

    wgt_buf_feeder_if #(.DATA_WID(DW), .SIZE(SZ), .ADDR_WID(AW)) bus ();

    wgt_buf_feeder #(.DATA_WID(DW), .SIZE(SZ), .ADDR_WID(AW), .BANK_DEPTH(72)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_kernel_size(kernel_size),
        .i_chn_num(chn_num), .i_tile_num(tile_num), .i_rpt_num(rpt_num),
        .i_bank_fill(bank_fill), .i_bank_fill_sel(bank_fill_sel),
        .o_bank_free(bank_free), .o_busy(busy), .o_done(done),
        .o_cfg_err(cfg_err), .o_ovf_err(ovf_err), .bus(bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Distinct nonzero word per bank/address/lane
    function automatic logic [15:0] wword(input logic b, input logic [6:0] a, input int lane);
        return {b, lane[2:0], a, 5'b10101};
    endfunction

    // Buffer model: data returns two cycles after rd_en, junk otherwise
    logic         p1_en = 1'b0, p2_en = 1'b0, p1_bank = 1'b0, p2_bank = 1'b0;
    logic [AW-1:0] p1_addr = '0, p2_addr = '0;
    always @(posedge clk) begin
        p1_en <= bus.rd_en; p1_bank <= bus.rd_bank_sel; p1_addr <= bus.rd_addr;
        p2_en <= p1_en;     p2_bank <= p1_bank;         p2_addr <= p1_addr;
    end
    always_comb begin
        for (int i = 0; i < SZ; i++)
            bus.rd_data[i] = p2_en ? wword(p2_bank, p2_addr, i) : 16'hDEAD;
    end

    typedef struct packed { logic bank; logic [6:0] addr; logic last; } rd_t;
    typedef struct packed { logic [15:0] data; logic last; logic [2:0] lane; int cyc; } ln_t;
    typedef struct packed { logic [1:0] pat; int remain; } bf_t;
    rd_t rd_q[$];
    ln_t ln_q[$];
    bf_t bf_q[$];

    int  checks = 0, failures = 0;
    int  done_cnt = 0, free_cnt = 0, last_rd_cyc = 0;
    bit  mon_en = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: pops scoreboard entries whenever the DUT presents output
    always @(negedge clk) begin : monitor
        rd_t e; ln_t l; bf_t f; int idx;
        if (mon_en) begin
            if (bus.rd_en) begin
                if (rd_q.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    e = rd_q.pop_front();
                    chk("rd_bank", bus.rd_bank_sel, e.bank);
                    chk("rd_addr", bus.rd_addr, e.addr);
                    if (e.addr != 0) chk("rd_contig", cyc - last_rd_cyc, 1);
                    last_rd_cyc = cyc;
                    for (int i = 0; i < SZ; i++) begin
                        l.data = wword(e.bank, e.addr, i); l.last = e.last;
                        l.lane = 3'(i); l.cyc = cyc + 3 + i;
                        ln_q.push_back(l);
                    end
                end
            end
            for (int i = 0; i < SZ; i++) begin
                if (bus.wgt_vld[i]) begin
                    idx = -1;
                    for (int j = 0; j < ln_q.size(); j++)
                        if (idx < 0 && ln_q[j].lane == 3'(i)) idx = j;
                    if (idx < 0) chk($sformatf("lane%0d_unexpected", i), 1, 0);
                    else begin
                        l = ln_q[idx]; ln_q.delete(idx);
                        chk($sformatf("lane%0d_data", i), bus.wgt_out[i], l.data);
                        chk($sformatf("lane%0d_last", i), bus.wgt_last[i], l.last);
                        chk($sformatf("lane%0d_time", i), cyc, l.cyc);
                    end
                end else if (bus.wgt_out[i] != '0 || bus.wgt_last[i]) begin
                    chk($sformatf("lane%0d_gate", i), {bus.wgt_last[i], bus.wgt_out[i]}, 0);
                end
            end
            if (bank_free != 2'b00) begin
                free_cnt++;
                if (bf_q.size() == 0) chk("free_unexpected", bank_free, 0);
                else begin
                    f = bf_q.pop_front();
                    chk("free_bank", bank_free, f.pat);
                    chk("free_after_reads", rd_q.size(), f.remain);
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic flush_sb();
        rd_q.delete(); ln_q.delete(); bf_q.delete();
    endtask

    task automatic do_reset();
        mon_en = 1'b0; rst = 1'b1; start = 1'b0; bank_fill = 1'b0;
        bus.arr_ready = 1'b1;
        tick(3);
        flush_sb();
        rst = 1'b0; mon_en = 1'b1;
        tick(1);
    endtask

    task automatic push_pass(input logic b, input int depth);
        rd_t e;
        for (int a = 0; a < depth; a++) begin
            e.bank = b; e.addr = 7'(a); e.last = (a == depth - 1);
            rd_q.push_back(e);
        end
    endtask

    task automatic push_free(input logic [1:0] pat, input int remain);
        bf_t f;
        f.pat = pat; f.remain = remain;
        bf_q.push_back(f);
    endtask

    task automatic start_job(input int k, input int c, input int t, input int r);
        kernel_size = 4'(k); chn_num = 3'(c); tile_num = 3'(t); rpt_num = 3'(r);
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic fill(input logic b);
        bank_fill = 1'b1; bank_fill_sel = b; tick(1); bank_fill = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0, n;
        d0 = done_cnt; n = 0;
        while (done_cnt == d0 && n < budget) begin tick(1); n++; end
        if (done_cnt == d0) chk("done_timeout", 0, 1);
        tick(2);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("lane_q_drained", ln_q.size(), 0);
        chk("free_q_drained", bf_q.size(), 0);
        chk("busy_after_done", busy, 0);
    endtask

    task automatic wait_rd(input int budget);
        int n = 0;
        while (!bus.rd_en && n < budget) begin tick(1); n++; end
        if (!bus.rd_en) chk("rd_timeout", 0, 1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int f0, d0, seen;
        bus.arr_ready = 1'b1;

        // 1. Single bank, reset state first
        do_reset();
        chk("rst_rd_en", bus.rd_en, 0);
        chk("rst_vld", bus.wgt_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_free", bank_free, 0);
        chk("rst_errs", {cfg_err, ovf_err, done}, 0);
        f0 = free_cnt; d0 = done_cnt;
        fill(1'b0);
        push_pass(1'b0, 9); push_free(2'b01, 0);
        start_job(3, 0, 0, 0);
        chk("t1_busy", busy, 1);
        wait_done(400);
        chk("t1_free_cnt", free_cnt - f0, 1);
        chk("t1_done_cnt", done_cnt - d0, 1);

        // 2. Ping-pong across two tiles
        do_reset();
        f0 = free_cnt; d0 = done_cnt;
        fill(1'b0);
        push_pass(1'b0, 9); push_free(2'b01, 9);
        push_pass(1'b1, 9); push_free(2'b10, 0);
        start_job(3, 0, 1, 0);
        wait_rd(50);
        fill(1'b1);
        wait_done(400);
        chk("t2_free_cnt", free_cnt - f0, 2);
        chk("t2_done_cnt", done_cnt - d0, 1);
        chk("t2_ovf", ovf_err, 0);

        // 3. Replay a full-depth bank three times
        do_reset();
        f0 = free_cnt;
        fill(1'b0);
        repeat (3) push_pass(1'b0, 72);
        push_free(2'b01, 0);
        start_job(3, 7, 0, 2);
        wait_done(1000);
        chk("t3_free_cnt", free_cnt - f0, 1);

        // 4. Array stall holds off the reads
        do_reset();
        bus.arr_ready = 1'b0;
        fill(1'b0);
        push_pass(1'b0, 9); push_free(2'b01, 0);
        start_job(3, 0, 0, 0);
        seen = 0;
        repeat (10) begin tick(1); if (bus.rd_en) seen++; end
        chk("t4_no_rd_stalled", seen, 0);
        bus.arr_ready = 1'b1;
        tick(1);
        chk("t4_rd_lat1", bus.rd_en, 0);
        tick(1);
        chk("t4_rd_lat2", bus.rd_en, 1);
        wait_done(400);

        // 5a. Config errors and the 72-word boundary
        do_reset();
        start_job(4, 7, 0, 0);
        tick(1);
        chk("t5_cfg_err_128", cfg_err, 1);
        chk("t5_busy_128", busy, 0);
        start_job(3, 7, 0, 0);
        tick(1);
        chk("t5_cfg_ok_72", cfg_err, 0);
        chk("t5_busy_72", busy, 1);
        do_reset();
        start_job(0, 3, 0, 0);
        tick(1);
        chk("t5_cfg_err_0", cfg_err, 1);
        chk("t5_busy_0", busy, 0);

        // 5b. Overfill, then a depth-1 job still frees exactly once
        do_reset();
        f0 = free_cnt;
        fill(1'b0);
        fill(1'b0);
        tick(1);
        chk("t5_ovf_set", ovf_err, 1);
        chk("t5_no_free", free_cnt - f0, 0);
        push_pass(1'b0, 1); push_free(2'b01, 0);
        start_job(1, 0, 0, 0);
        chk("t5_ovf_cleared", ovf_err, 0);
        wait_done(200);
        chk("t5_free_once", free_cnt - f0, 1);

        // 6. Reset in the middle of a burst
        do_reset();
        fill(1'b0);
        push_pass(1'b0, 72);
        start_job(3, 7, 0, 0);
        seen = 0;
        while (!(bus.rd_en && bus.rd_addr == 7'd20) && seen < 200) begin tick(1); seen++; end
        chk("t6_reach_addr20", bus.rd_addr, 20);
        mon_en = 1'b0; rst = 1'b1;
        tick(1);
        chk("t6_rst_rd", {bus.rd_en, bus.rd_bank_sel, bus.rd_addr}, 0);
        chk("t6_rst_lanes", {bus.wgt_vld, bus.wgt_last}, 0);
        chk("t6_rst_out", bus.wgt_out, 0);
        chk("t6_rst_status", {bank_free, busy, done, cfg_err, ovf_err}, 0);
        tick(2);
        rst = 1'b0; flush_sb(); mon_en = 1'b1;
        tick(1);
        start_job(3, 0, 0, 0);
        seen = 0;
        repeat (8) begin tick(1); if (bus.rd_en) seen++; end
        chk("t6_bank_full_cleared", seen, 0);
        push_pass(1'b0, 9); push_free(2'b01, 0);
        fill(1'b0);
        wait_done(400);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/wgt_buf_feeder.md
Name: wgt_buf_feeder

Overview:
Drains the ping-pong weight buffer that sits in front of the cubic (systolic) array, which img2col_weight fills. It tracks which bank is full, issues reads with the buffer's 2-cycle read latency, and streams one weight column per lane into the array with diagonal skew. It can replay a bank several times, then frees the bank back to the writer and moves to the other bank.

Parameters:
DATA_WID, 16, weight word width
SIZE, 8, lanes (kernel sets / array columns)
ADDR_WID, 7, bank address width
BANK_DEPTH, 72, max words per lane per bank (9 taps x 8 channels)

Ports:
clock  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  pulse; latches config, ignored unless IDLE
kernel_size  in  4  kernel edge (taps = kernel_size^2)
chn_num  in  3  channels per bank minus 1
tile_num  in  3  bank fills per job minus 1
rpt_num  in  3  replays per bank minus 1
bank_fill  in  1  pulse from writer: bank_fill_sel now full
bank_fill_sel  in  1  bank id for bank_fill
arr_ready  in  1  array can accept a new pass
rd_en  out  1  buffer read enable
rd_bank_sel  out  1  bank being read
rd_addr  out  ADDR_WID  shared read address
rd_data  in  DATA_WID x SIZE  buffer read data, valid 2 cycles after rd_en
wgt_out  out  DATA_WID x SIZE  skewed weights to array
wgt_vld  out  SIZE  per-lane valid
wgt_last  out  SIZE  per-lane last word of pass
bank_free  out  2  one-cycle pulse per bank released
busy  out  1  job in progress
done  out  1  one-cycle pulse at job end
cfg_err  out  1  sticky, cleared on start
ovf_err  out  1  sticky, cleared on start

Behaviour:
- Reset: all outputs 0, bank_full[1:0]=0, cur_bank=0, all counters 0, skew pipeline flushed, FSM=IDLE. Reset mid-pass aborts the pass; outputs are 0 in the cycle after rst is sampled.
- depth = kernel_size*kernel_size*(chn_num+1), computed to 8 bits at start. depth==0 or depth>BANK_DEPTH: cfg_err=1, stay IDLE, busy=0.
- bank_full[b] is set by bank_fill when bank_fill_sel==b and cleared in RELEASE. It updates in every state, IDLE included, so the writer may pre-fill.
- bank_fill to a bank that is already full, including the same cycle as its release: ovf_err=1, fill ignored. Fill of the other bank in the same cycle as a release: both take effect.
- FSM:
  - IDLE: on a legal start, latch config, busy=1, go to WAIT_BANK.
  - WAIT_BANK: when bank_full[cur_bank] && arr_ready, go to ISSUE next cycle.
  - ISSUE: rd_en=1, rd_bank_sel=cur_bank, rd_addr=0..depth-1, one per cycle with no gaps. The cycle after depth-1 goes to DRAIN.
  - DRAIN: SIZE+2 cycles, then pass_cnt++. If pass_cnt<=rpt_num, go to WAIT_BANK on the same bank. Otherwise clear pass_cnt and go to RELEASE.
  - RELEASE: one cycle; bank_free[cur_bank]=1, clear bank_full[cur_bank], toggle cur_bank, tile_cnt++. If the finished tile was number tile_num: done=1, busy=0, go to IDLE. Otherwise go to WAIT_BANK.
- Data path:
  - rd_data for an address issued at cycle t is captured at t+2.
  - Lane i drives wgt_out[i]/wgt_vld[i] at t+3+i.
  - wgt_last[i] accompanies the word from address depth-1.
  - wgt_out is 0 whenever wgt_vld is 0.
- No backpressure inside a pass; arr_ready is sampled only in WAIT_BANK.
- start while busy is ignored and leaves the error flags unchanged.

Decomposition:
- Package wgt_feed_pkg: FSM state enum (IDLE, WAIT_BANK, ISSUE, DRAIN, RELEASE), RD_LAT=2, BANK_DEPTH, and a depth-calculation function shared with img2col_weight.
- Sub-module wgt_skew_line: per-lane delay of i cycles for data, valid and last, instantiated as a SIZE-lane triangle.

Test Plan:
1. Single bank: start k=3, chn=0, tile=0, rpt=0; fill bank0; arr_ready=1. Expect rd_addr 0..8 over 9 consecutive cycles, wgt_vld[0] high 9 cycles starting 3 cycles after the first rd_en, wgt_vld[7] 7 cycles later, wgt_last on the 9th word, bank_free=2'b01, then done.
2. Ping-pong: tile=1; fill bank0, then bank1 during the bank0 pass. Expect rd_bank_sel 0 then 1, bank_free 01 then 10, one done, no ovf_err.
3. Replay: rpt=2, k=3, chn=7 (depth 72). Expect three 72-cycle read bursts on bank0 and bank_free[0] only after the third DRAIN.
4. Stall: bank0 full, arr_ready=0 for 10 cycles. Expect no rd_en; raise arr_ready and expect rd_en 2 cycles later (WAIT_BANK→ISSUE).
5. Errors:
   - start with k=4, chn=7 (depth 128): expect cfg_err=1, busy=0.
   - Fill bank0 twice without a release: expect ovf_err=1 and bank_free count unaffected.
6. Reset mid-ISSUE at addr 20. Expect all outputs 0 the next cycle, bank_full cleared, and a following job running normally from addr 0.
